// File: rtl/factor_game_pkg.sv
// Shared constants for the factorization quiz controller: state codes,
// answer table and switch-to-digit helper.
package factor_game_pkg;

   localparam logic [3:0] ST_READY    = 4'b0010;
   localparam logic [3:0] ST_QUESTION = 4'b0011;
   localparam logic [3:0] ST_INPUT    = 4'b0100;
   localparam logic [3:0] ST_JUDGE    = 4'b0101;
   localparam logic [3:0] ST_RESULT   = 4'b0110;

   typedef enum logic [3:0] {
      S_READY    = ST_READY,
      S_QUESTION = ST_QUESTION,
      S_INPUT    = ST_INPUT,
      S_JUDGE    = ST_JUDGE,
      S_RESULT   = ST_RESULT
   } state_e;

   // entry [0] sits in the low nibble: answers 1,2,3,4,5,6,7,8,9,3
   localparam logic [9:0][3:0] ANS_ROM = {4'd3, 4'd9, 4'd8, 4'd7, 4'd6,
                                          4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

   localparam logic [3:0] DASH_CODE = 4'd0;

   function automatic logic [3:0] sw_code(input logic [3:0] sw);
      return (sw > 4'd9) ? DASH_CODE : sw;
   endfunction

endpackage

// File: rtl/factor_game_ctrl_if.sv
// Board-side bundle of the quiz controller: keys, switches and decoder drive.
interface factor_game_ctrl_if;
   logic       nKEY_START;
   logic       nKEY_ENTER;
   logic [3:0] SW;
   logic [3:0] STATE;
   logic [3:0] QUE;
   logic [3:0] SEG_Q;
   logic [3:0] SCORE;
   logic       TIMEOUT;

   modport master (output nKEY_START, nKEY_ENTER, SW,
                   input  STATE, QUE, SEG_Q, SCORE, TIMEOUT);
   modport slave  (input  nKEY_START, nKEY_ENTER, SW,
                   output STATE, QUE, SEG_Q, SCORE, TIMEOUT);
endinterface

// File: rtl/factor_game_ctrl_key_edge.sv
// Push-key front end: 2-flop synchronizer plus falling-edge pulse.
module key_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic pulse
);
   logic       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic       armed_q, armed_d;
   logic [1:0] fill_q, fill_d;

   // Arm only once a released level has come through the synchronizer,
   // so a key held across reset release never produces a pulse.
   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      fill_d  = {fill_q[0], 1'b1};
      armed_d = armed_q | (fill_q[1] & sync2_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         fill_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         fill_q  <= fill_d;
         armed_q <= armed_d;
      end
   end

   assign pulse = armed_q & prev_q & ~sync2_q;
endmodule

// File: rtl/factor_game_ctrl.sv
// Quiz sequencing FSM: READY -> QUESTION -> INPUT -> JUDGE (x NUM_Q) -> RESULT.
// Define QUESTION_SHUFFLE_EN to start each game at a free-running question index.
module factor_game_ctrl
   import factor_game_pkg::*;
#(
   parameter int TICK_DIV  = 50000000,
   parameter int SHOW_SEC  = 3,
   parameter int INPUT_SEC = 10,
   parameter int NUM_Q     = 10
) (
   input  logic              CLK,
   input  logic              nRST,
   factor_game_ctrl_if.slave bus
);
   localparam int              TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]   TICK_MAX   = TW'(TICK_DIV - 1);
   localparam logic [7:0]      SHOW_LAST  = 8'(SHOW_SEC - 1);
   localparam logic [7:0]      INPUT_LAST = 8'(INPUT_SEC - 1);
   localparam logic [3:0]      Q_LAST     = 4'(NUM_Q - 1);

   state_e        state_q, state_d;
   logic [3:0]    que_q, que_d, seg_q_q, seg_q_d, score_q, score_d, ans_q, ans_d;
   logic          timeout_q, timeout_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [7:0]    sec_cnt_q, sec_cnt_d;
   logic          start_p, enter_p, tick, last_q;
   logic [3:0]    first_que, que_next;

   key_edge u_start (.clk(CLK), .rst_n(nRST), .key_n(bus.nKEY_START), .pulse(start_p));
   key_edge u_enter (.clk(CLK), .rst_n(nRST), .key_n(bus.nKEY_ENTER), .pulse(enter_p));

`ifdef QUESTION_SHUFFLE_EN
   logic [3:0] shuf_q, shuf_d, qcnt_q, qcnt_d;

   always_comb begin
      shuf_d = (shuf_q == Q_LAST) ? 4'd0 : shuf_q + 4'd1;
      qcnt_d = qcnt_q;
      if (state_q == S_READY && start_p)      qcnt_d = 4'd0;
      else if (state_q == S_JUDGE && !last_q) qcnt_d = qcnt_q + 4'd1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         shuf_q <= '0;
         qcnt_q <= '0;
      end else begin
         shuf_q <= shuf_d;
         qcnt_q <= qcnt_d;
      end
   end

   assign first_que = shuf_q;
   assign last_q    = (qcnt_q == Q_LAST);
   assign que_next  = (que_q == Q_LAST) ? 4'd0 : que_q + 4'd1;
`else
   assign first_que = 4'd0;
   assign last_q    = (que_q == Q_LAST);
   assign que_next  = que_q + 4'd1;
`endif

   assign tick = (tick_cnt_q == TICK_MAX);

   always_comb begin
      state_d    = state_q;
      que_d      = que_q;
      seg_q_d    = seg_q_q;
      score_d    = score_q;
      ans_d      = ans_q;
      timeout_d  = timeout_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      sec_cnt_d  = tick ? sec_cnt_q + 8'd1 : sec_cnt_q;
      case (state_q)
         S_READY: if (start_p) begin
            state_d   = S_QUESTION;
            que_d     = first_que;
            score_d   = 4'd0;
            timeout_d = 1'b0;
         end
         S_QUESTION: if (tick && sec_cnt_q == SHOW_LAST) state_d = S_INPUT;
         S_INPUT: begin
            seg_q_d = sw_code(bus.SW);
            // enter beats a coincident timeout
            if (enter_p) begin
               ans_d   = seg_q_q;
               state_d = S_JUDGE;
            end else if (tick && sec_cnt_q == INPUT_LAST) begin
               ans_d     = DASH_CODE;
               timeout_d = 1'b1;
               state_d   = S_JUDGE;
            end
         end
         S_JUDGE: begin
            if (ans_q == ANS_ROM[que_q] && score_q != 4'hF) score_d = score_q + 4'd1;
            if (last_q) state_d = S_RESULT;
            else begin
               que_d     = que_next;
               timeout_d = 1'b0;
               state_d   = S_QUESTION;
            end
         end
         S_RESULT: if (start_p) state_d = S_READY;
         default:  state_d = S_READY;
      endcase
      // every state entry restarts its time window
      if (state_d != state_q) begin
         tick_cnt_d = '0;
         sec_cnt_d  = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= S_READY;
         que_q      <= '0;
         seg_q_q    <= '0;
         score_q    <= '0;
         ans_q      <= '0;
         timeout_q  <= 1'b0;
         tick_cnt_q <= '0;
         sec_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         que_q      <= que_d;
         seg_q_q    <= seg_q_d;
         score_q    <= score_d;
         ans_q      <= ans_d;
         timeout_q  <= timeout_d;
         tick_cnt_q <= tick_cnt_d;
         sec_cnt_q  <= sec_cnt_d;
      end
   end

   assign bus.STATE   = state_q;
   assign bus.QUE     = que_q;
   assign bus.SEG_Q   = seg_q_q;
   assign bus.SCORE   = score_q;
   assign bus.TIMEOUT = timeout_q;
endmodule

// File: tb/tb_factor_game_ctrl.sv
// Directed bench for factor_game_ctrl with a short tick (4 cycles), 3-question game.
module tb_factor_game_ctrl;
   import factor_game_pkg::*;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   factor_game_ctrl_if bus();

   factor_game_ctrl #(.TICK_DIV(4), .SHOW_SEC(2), .INPUT_SEC(3), .NUM_Q(3)) dut (
      .CLK (CLK),
      .nRST(nRST),
      .bus (bus)
   );

   typedef struct {
      logic [3:0] sw;
      bit         enter;
      logic [3:0] seg;
      bit         to;
      logic [3:0] score;
      logic [3:0] nstate;
      logic [3:0] que;
   } vec_t;

   vec_t tbl[7];
   int   nvec = 0;
   int   nerr = 0;

   task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_state(input logic [3:0] s, input int maxc, input string nm);
      int k = 0;
      while (bus.STATE !== s && k < maxc) begin
         @(negedge CLK);
         k++;
      end
      check(nm, bus.STATE, s);
   endtask

   task automatic press_start(input logic [3:0] target, input string nm);
      @(posedge CLK);
      #1 bus.nKEY_START = 1'b0;
      wait_state(target, 10, nm);
      bus.nKEY_START = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"}, bus.STATE, ST_READY);
      check({tag, "_que"}, bus.QUE, 4'd0);
      check({tag, "_seg"}, bus.SEG_Q, 4'd0);
      check({tag, "_score"}, bus.SCORE, 4'd0);
      check({tag, "_to"}, {3'b0, bus.TIMEOUT}, 4'd0);
   endtask

   task automatic run_vec(input int i);
      vec_t v = tbl[i];
      wait_state(ST_INPUT, 40, $sformatf("v%0d_reach_input", i));
      bus.SW = v.sw;
      if (v.enter) begin
         @(negedge CLK);
         @(posedge CLK);
         #1 bus.nKEY_ENTER = 1'b0;
      end
      wait_state(ST_JUDGE, 30, $sformatf("v%0d_reach_judge", i));
      bus.nKEY_ENTER = 1'b1;
      check($sformatf("v%0d_seg", i), bus.SEG_Q, v.seg);
      check($sformatf("v%0d_to", i), {3'b0, bus.TIMEOUT}, {3'b0, v.to});
      @(negedge CLK);
      check($sformatf("v%0d_next_state", i), bus.STATE, v.nstate);
      check($sformatf("v%0d_que", i), bus.QUE, v.que);
      check($sformatf("v%0d_score", i), bus.SCORE, v.score);
      check($sformatf("v%0d_to_after", i), {3'b0, bus.TIMEOUT},
            (v.nstate == ST_QUESTION) ? 4'd0 : {3'b0, v.to});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int qlen;
      // game A: all correct; game B: correct, timeout (then edge case); game C: two correct
      tbl[0] = '{4'd1,  1'b1, 4'd1, 1'b0, 4'd1, ST_QUESTION, 4'd1};
      tbl[1] = '{4'd2,  1'b1, 4'd2, 1'b0, 4'd2, ST_QUESTION, 4'd2};
      tbl[2] = '{4'd3,  1'b1, 4'd3, 1'b0, 4'd3, ST_RESULT,   4'd2};
      tbl[3] = '{4'd1,  1'b1, 4'd1, 1'b0, 4'd1, ST_QUESTION, 4'd1};
      tbl[4] = '{4'd5,  1'b0, 4'd5, 1'b1, 4'd1, ST_QUESTION, 4'd2};
      tbl[5] = '{4'd1,  1'b1, 4'd1, 1'b0, 4'd1, ST_QUESTION, 4'd1};
      tbl[6] = '{4'd2,  1'b1, 4'd2, 1'b0, 4'd2, ST_QUESTION, 4'd2};

      nRST = 1'b0;
      bus.nKEY_START = 1'b0;
      bus.nKEY_ENTER = 1'b1;
      bus.SW = 4'd0;
      repeat (3) @(negedge CLK);
      check_reset_vals("rst");
      nRST = 1'b1;
      repeat (10) @(negedge CLK);
      check("held_start_ready", bus.STATE, ST_READY);
      bus.nKEY_START = 1'b1;
      repeat (4) @(negedge CLK);
      check("release_ready", bus.STATE, ST_READY);

      @(posedge CLK);
      #1 bus.nKEY_ENTER = 1'b0;
      repeat (5) @(negedge CLK);
      bus.nKEY_ENTER = 1'b1;
      check("enter_ignored_ready", bus.STATE, ST_READY);
      repeat (3) @(negedge CLK);

      @(posedge CLK);
      #1 bus.nKEY_START = 1'b0;
      wait_state(ST_QUESTION, 10, "start_to_question");
      bus.nKEY_START = 1'b1;
      check("q0_que", bus.QUE, 4'd0);
      qlen = 0;
      while (bus.STATE === ST_QUESTION && qlen < 20) begin
         qlen++;
         @(negedge CLK);
      end
      check("question_len", 4'(qlen), 4'd8);
      check("question_to_input", bus.STATE, ST_INPUT);

      for (int i = 0; i < 3; i++) run_vec(i);
      press_start(ST_READY, "result_to_ready");
      check("ready_score_held", bus.SCORE, 4'd3);
      press_start(ST_QUESTION, "game_b_start");
      check("game_b_score_clr", bus.SCORE, 4'd0);
      check("game_b_que", bus.QUE, 4'd0);

      for (int i = 3; i < 5; i++) run_vec(i);
      // enter pulse lands on the last INPUT cycle, where the timeout also fires
      wait_state(ST_INPUT, 40, "edge_reach_input");
      bus.SW = 4'd3;
      repeat (9) @(posedge CLK);
      #1 bus.nKEY_ENTER = 1'b0;
      wait_state(ST_JUDGE, 10, "edge_reach_judge");
      bus.nKEY_ENTER = 1'b1;
      check("edge_to", {3'b0, bus.TIMEOUT}, 4'd0);
      check("edge_seg", bus.SEG_Q, 4'd3);
      @(negedge CLK);
      check("edge_state", bus.STATE, ST_RESULT);
      check("edge_score", bus.SCORE, 4'd2);

      press_start(ST_READY, "b_result_to_ready");
      press_start(ST_QUESTION, "game_c_start");
      for (int i = 5; i < 7; i++) run_vec(i);

      wait_state(ST_INPUT, 40, "c_reach_input");
      bus.SW = 4'd12;
      repeat (2) @(negedge CLK);
      check("sw12_dash", bus.SEG_Q, 4'd0);
      check("pre_reset_score", bus.SCORE, 4'd2);
      #2 nRST = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge CLK);
      nRST = 1'b1;
      repeat (2) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
